ans_encoder: RTL and testbench

rANS encoder, counterpart of the existing ANS decoder inside the `ans` codec. Consumes 4-bit symbols over a valid/ready handshake and looks up each symbol's count and cumulative count through the table read port served by the loader. Keeps a 16-bit coder state and emits renormalisation nibbles on a 4-bit valid/ready output. A flush request drains the final state.

---
 rtl/ans_encoder_if.sv | 30 +++
 rtl/ans_encoder.sv | 208 ++++++++++++++++++++
 tb/tb_ans_encoder.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ans_encoder_if.sv
// Bundle of the ans_encoder handshake buses: symbol input, nibble output, table read port.
// Pure wiring, no latency.
// Backpressure: in_rdy/out_rdy/read_rdy gate each bus.
// Ports: ena, in, flush, in_vld/in_rdy, out, out_vld/out_rdy,
//        read_type, read_query, read_result, read_rdy, err.
interface ans_encoder_if;
    logic       ena;
    logic [3:0] in;
    logic       flush;
    logic       in_vld;
    logic       in_rdy;
    logic [3:0] out;
    logic       out_vld;
    logic       out_rdy;
    logic [1:0] read_type;
    logic [7:0] read_query;
    logic [7:0] read_result;
    logic       read_rdy;
    logic       err;

    // slave = encoder side, master = host/table side
    modport slave (
        input  ena, in, flush, in_vld, out_rdy, read_result, read_rdy,
        output in_rdy, out, out_vld, read_type, read_query, err
    );
    modport master (
        output ena, in, flush, in_vld, out_rdy, read_result, read_rdy,
        input  in_rdy, out, out_vld, read_type, read_query, err
    );
endinterface

// File: rtl/ans_encoder.sv
// rANS encoder: 4-bit symbols in, renormalisation nibbles out, 16-bit state x in [4096, 65536).
// Latency: 20 cycles accept-to-ready per symbol without renorm (5 with ANS_ENC_COMB_DIV_EN), +1 per nibble.
// Backpressure: out/out_vld hold while !out_rdy; read_type/read_query hold until read_rdy.
// Ports: clk, rst (sync, active high), bus (ans_encoder_if.slave).
// Option: define ANS_ENC_COMB_DIV_EN for a single-cycle combinational divide in place of the
//         16-step restoring divider; emitted nibbles and state are identical either way.
module ans_encoder #(
    parameter int M_LOG = 4,
    parameter int L_LOG = 12
) (
    input  logic          clk,
    input  logic          rst,
    ans_encoder_if.slave  bus
);

    localparam logic [15:0] X_INIT = 16'(1 << L_LOG);

    typedef enum logic [2:0] {
        S_IDLE, S_CNT, S_CUM, S_RENORM, S_DIV, S_UPDATE, S_FLUSH
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_x, w_x_nxt;
    logic [3:0]  r_f, w_f_nxt;
    logic [7:0]  r_c, w_c_nxt;
    logic [15:0] r_quo, w_quo_nxt;
    logic [3:0]  r_rem, w_rem_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [3:0]  r_out, w_out_nxt;
    logic        r_out_vld, w_out_vld_nxt;
    logic [1:0]  r_read_type, w_read_type_nxt;
    logic [7:0]  r_read_query, w_read_query_nxt;
    logic        r_err, w_err_nxt;
    logic        w_accept;

`ifndef ANS_ENC_COMB_DIV_EN
    // One restoring step: shift in the next dividend bit, subtract f if it fits.
    logic [4:0] w_trial;
    assign w_trial = {r_rem, r_quo[15]};
`endif

    // Renormalise while x >= f << L_LOG; 17 bits so the bound never wraps.
    function automatic logic f_need_renorm(input logic [15:0] x, input logic [3:0] f);
        return ({1'b0, x} >= ({13'b0, f} << L_LOG));
    endfunction

    assign bus.in_rdy     = (r_state == S_IDLE) && bus.ena && !rst;
    assign w_accept       = bus.in_vld && bus.in_rdy;
    assign bus.out        = r_out;
    assign bus.out_vld    = r_out_vld;
    assign bus.read_type  = r_read_type;
    assign bus.read_query = r_read_query;
    assign bus.err        = r_err;

    always_comb begin
        w_state_nxt      = r_state;
        w_x_nxt          = r_x;
        w_f_nxt          = r_f;
        w_c_nxt          = r_c;
        w_quo_nxt        = r_quo;
        w_rem_nxt        = r_rem;
        w_cnt_nxt        = r_cnt;
        w_out_nxt        = r_out;
        w_out_vld_nxt    = r_out_vld;
        w_read_type_nxt  = r_read_type;
        w_read_query_nxt = r_read_query;
        w_err_nxt        = r_err;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (bus.flush) begin
                        w_out_nxt     = r_x[3:0];
                        w_out_vld_nxt = 1'b1;
                        w_cnt_nxt     = 4'd0;
                        w_state_nxt   = S_FLUSH;
                    end else begin
                        w_read_type_nxt  = 2'b00;
                        w_read_query_nxt = {4'b0, bus.in};
                        w_state_nxt      = S_CNT;
                    end
                end
            end
            S_CNT: begin
                if (bus.read_rdy) begin
                    w_f_nxt = bus.read_result[3:0];
                    if (bus.read_result[3:0] == 4'd0) begin
                        // zero-count symbol cannot be coded: flag and drop it
                        w_err_nxt        = 1'b1;
                        w_read_query_nxt = 8'd0;
                        w_state_nxt      = S_IDLE;
                    end else begin
                        w_read_type_nxt = 2'b01;
                        w_state_nxt     = S_CUM;
                    end
                end
            end
            S_CUM: begin
                if (bus.read_rdy) begin
                    w_c_nxt          = bus.read_result;
                    w_read_type_nxt  = 2'b00;
                    w_read_query_nxt = 8'd0;
                    // skip RENORM entirely when no nibble is due
                    if (f_need_renorm(r_x, r_f)) begin
                        w_out_nxt     = r_x[3:0];
                        w_out_vld_nxt = 1'b1;
                        w_state_nxt   = S_RENORM;
                    end else begin
                        w_quo_nxt   = r_x;
                        w_rem_nxt   = 4'd0;
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = S_DIV;
                    end
                end
            end
            S_RENORM: begin
                if (bus.out_rdy) begin
                    w_x_nxt = r_x >> 4;
                    if (f_need_renorm(w_x_nxt, r_f)) begin
                        w_out_nxt = w_x_nxt[3:0];
                    end else begin
                        w_out_vld_nxt = 1'b0;
                        w_quo_nxt     = w_x_nxt;
                        w_rem_nxt     = 4'd0;
                        w_cnt_nxt     = 4'd0;
                        w_state_nxt   = S_DIV;
                    end
                end
            end
            S_DIV: begin
`ifdef ANS_ENC_COMB_DIV_EN
                w_quo_nxt   = r_x / {12'b0, r_f};
                w_rem_nxt   = 4'(r_x % {12'b0, r_f});
                w_state_nxt = S_UPDATE;
`else
                // r_quo starts as the dividend and fills with quotient bits from the right
                if (w_trial >= {1'b0, r_f}) begin
                    w_rem_nxt = 4'(w_trial - {1'b0, r_f});
                    w_quo_nxt = {r_quo[14:0], 1'b1};
                end else begin
                    w_rem_nxt = w_trial[3:0];
                    w_quo_nxt = {r_quo[14:0], 1'b0};
                end
                w_cnt_nxt = r_cnt + 4'd1;
                if (r_cnt == 4'd15) begin
                    w_state_nxt = S_UPDATE;
                end
`endif
            end
            S_UPDATE: begin
                // quotient < 2^(16-M_LOG) after renorm, so the sum stays in 16 bits
                w_x_nxt     = (r_quo << M_LOG) + {12'b0, r_rem} + {8'b0, r_c};
                w_state_nxt = S_IDLE;
            end
            S_FLUSH: begin
                if (bus.out_rdy) begin
                    if (r_cnt == 4'd3) begin
                        w_x_nxt       = X_INIT;
                        w_out_nxt     = 4'd0;
                        w_out_vld_nxt = 1'b0;
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_x_nxt   = r_x >> 4;
                        w_out_nxt = w_x_nxt[3:0];
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x          <= X_INIT;
            r_f          <= 4'd0;
            r_c          <= 8'd0;
            r_quo        <= 16'd0;
            r_rem        <= 4'd0;
            r_cnt        <= 4'd0;
            r_out        <= 4'd0;
            r_out_vld    <= 1'b0;
            r_read_type  <= 2'b00;
            r_read_query <= 8'd0;
            r_err        <= 1'b0;
        end else begin
            r_x          <= w_x_nxt;
            r_f          <= w_f_nxt;
            r_c          <= w_c_nxt;
            r_quo        <= w_quo_nxt;
            r_rem        <= w_rem_nxt;
            r_cnt        <= w_cnt_nxt;
            r_out        <= w_out_nxt;
            r_out_vld    <= w_out_vld_nxt;
            r_read_type  <= w_read_type_nxt;
            r_read_query <= w_read_query_nxt;
            r_err        <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_ans_encoder.sv
// Directed bench for ans_encoder: table responder, nibble scoreboard, textbook rANS model.
// Latency: n/a.
// Backpressure: exercises out_rdy stalls and delayed read_rdy.
module tb_ans_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ans_encoder_if bus ();

    ans_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [3:0] sb[$];
    logic [3:0] tcnt[16];
    logic [7:0] tcum[16];
    int         rd_delay = 0;
    int         mx = 4096;

`ifdef ANS_ENC_COMB_DIV_EN
    localparam int EXP_LAT = 5;
`else
    localparam int EXP_LAT = 20;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Table read responder: result follows the registered query, read_rdy after rd_delay cycles.
    initial begin
        logic [9:0] last;
        int wcnt;
        last = 10'h3ff;
        wcnt = 0;
        bus.read_rdy    = 1'b0;
        bus.read_result = 8'd0;
        forever begin
            @(posedge clk);
            #1;
            if ({bus.read_type, bus.read_query} != last) begin
                last = {bus.read_type, bus.read_query};
                wcnt = 0;
            end else if (wcnt < 100) begin
                wcnt++;
            end
            bus.read_rdy    = (wcnt >= rd_delay);
            bus.read_result = (bus.read_type == 2'b01) ? tcum[bus.read_query[3:0]]
                                                       : {4'b0, tcnt[bus.read_query[3:0]]};
        end
    end

    // Output monitor: every accepted nibble must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.out_vld && bus.out_rdy) begin
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_nibble: observed=%0h expected=none", bus.out);
            end
            if (sb.size() > 0) begin
                logic [3:0] e;
                e = sb.pop_front();
                chk("nibble", {28'b0, bus.out}, {28'b0, e});
            end
        end
    end

    task automatic send(input logic fl, input logic [3:0] s);
        logic ok;
        int n;
        @(posedge clk);
        #1;
        bus.in     = s;
        bus.flush  = fl;
        bus.in_vld = 1'b1;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = bus.in_rdy;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_vld = 1'b0;
        bus.flush  = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.in_rdy && cyc < 400);
        if (!bus.in_rdy) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic push4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        sb.push_back(a); sb.push_back(b); sb.push_back(c); sb.push_back(d);
    endtask

    // Textbook rANS step (b = 16, L = 4096, M = 16).
    task automatic m_enc(input int s);
        int f;
        f = int'(tcnt[s]);
        while (mx >= f * 4096) begin
            sb.push_back(4'(mx & 15));
            mx = mx >> 4;
        end
        mx = (mx / f) * 16 + (mx % f) + int'(tcum[s]);
    endtask

    task automatic m_flush();
        for (int k = 0; k < 4; k++) begin
            sb.push_back(4'((mx >> (4 * k)) & 15));
        end
        mx = 4096;
    endtask

    initial begin
        int cyc;
        bus.ena     = 1'b1;
        bus.in      = 4'd0;
        bus.flush   = 1'b0;
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tcnt[i] = 4'd1;
            tcum[i] = 8'(i);
        end

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_rdy", {31'b0, bus.in_rdy}, 32'd0);
        chk("rst_outs", {14'b0, bus.out, bus.out_vld, bus.read_type, bus.read_query, bus.err},
            32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_rdy_after_rst", {31'b0, bus.in_rdy}, 32'd1);
        bus.ena = 1'b0;
        @(negedge clk);
        chk("ena_low_in_rdy", {31'b0, bus.in_rdy}, 32'd0);
        bus.ena = 1'b1;

        // uniform table, symbol 5; ena dropped mid-symbol
        sb.push_back(4'h0);
        send(1'b0, 4'd5);
        bus.ena = 1'b0;
        repeat (40) @(negedge clk);
        chk("ena_low_no_accept", {31'b0, bus.in_rdy}, 32'd0);
        chk("uniform_renorm_done", sb.size(), 32'd0);
        bus.ena = 1'b1;
        wait_idle(cyc);
        push4(4'h5, 4'h0, 4'h0, 4'h1);
        send(1'b1, 4'd0);
        wait_idle(cyc);
        chk("uniform_flush_done", sb.size(), 32'd0);
        chk("uniform_err", {31'b0, bus.err}, 32'd0);

        // two-symbol table: encode 1, no renorm, x = 0x2008
        for (int i = 0; i < 16; i++) begin
            tcnt[i] = 4'd0;
            tcum[i] = 8'd16;
        end
        tcnt[0] = 4'd8; tcum[0] = 8'd0;
        tcnt[1] = 4'd8; tcum[1] = 8'd8;
        send(1'b0, 4'd1);
        wait_idle(cyc);
        chk("latency", cyc, EXP_LAT);
        chk("no_renorm", sb.size(), 32'd0);
        push4(4'h8, 4'h0, 4'h0, 4'h2);
        send(1'b1, 4'd0);
        wait_idle(cyc);
        chk("two_flush_done", sb.size(), 32'd0);

        // zero-count symbol: err, no output, x untouched
        send(1'b0, 4'd2);
        wait_idle(cyc);
        chk("zero_cnt_err", {31'b0, bus.err}, 32'd1);
        push4(4'h0, 4'h0, 4'h0, 4'h1);
        send(1'b1, 4'd0);
        wait_idle(cyc);
        chk("zero_cnt_flush_done", sb.size(), 32'd0);
        chk("err_sticky", {31'b0, bus.err}, 32'd1);

        // output stall on the first flush nibble
        send(1'b0, 4'd1);
        wait_idle(cyc);
        push4(4'h8, 4'h0, 4'h0, 4'h2);
        bus.out_rdy = 1'b0;
        send(1'b1, 4'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold", {27'b0, bus.out_vld, bus.out}, {27'b0, 1'b1, 4'h8});
            @(posedge clk);
            #1;
        end
        bus.out_rdy = 1'b1;
        wait_idle(cyc);
        chk("stall_flush_done", sb.size(), 32'd0);

        // delayed table reads
        rd_delay = 3;
        send(1'b0, 4'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("read_hold", {22'b0, bus.read_type, bus.read_query}, {22'b0, 2'b00, 8'h01});
        end
        wait_idle(cyc);
        push4(4'h8, 4'h0, 4'h0, 4'h2);
        send(1'b1, 4'd0);
        wait_idle(cyc);
        chk("delay_flush_done", sb.size(), 32'd0);
        rd_delay = 0;

        // reset pulse while dividing
        send(1'b0, 4'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("div_rst_in_rdy", {31'b0, bus.in_rdy}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("div_rst_outs", {14'b0, bus.out, bus.out_vld, bus.read_type, bus.read_query, bus.err},
            32'd0);
        chk("div_rst_idle", {31'b0, bus.in_rdy}, 32'd1);
        push4(4'h0, 4'h0, 4'h0, 4'h1);
        send(1'b1, 4'd0);
        wait_idle(cyc);
        chk("div_rst_flush_done", sb.size(), 32'd0);

        // skewed table, random symbols against the reference model
        begin
            int cnts[8] = '{5, 3, 2, 2, 1, 1, 1, 1};
            int acc;
            acc = 0;
            for (int i = 0; i < 16; i++) begin
                tcnt[i] = 4'd0;
                tcum[i] = 8'd16;
            end
            for (int i = 0; i < 8; i++) begin
                tcnt[i] = 4'(cnts[i]);
                tcum[i] = 8'(acc);
                acc += cnts[i];
            end
        end
        mx = 4096;
        for (int i = 0; i < 12; i++) begin
            int s;
            s = int'($urandom_range(0, 7));
            m_enc(s);
            send(1'b0, 4'(s));
            wait_idle(cyc);
        end
        m_flush();
        send(1'b1, 4'd0);
        wait_idle(cyc);
        chk("skew_done", sb.size(), 32'd0);
        chk("skew_err", {31'b0, bus.err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
